key_expand: RTL
===============

# key_expand

Generates the ten CryptoNight AES round keys from a 256-bit key and writes them, one 128-bit round key per cycle, into the key RAM write port (`we`/`waddr`/`din`). It sits between the Keccak state unit, which supplies the 256-bit key, and the key RAM. It fills one of two interleaved key slots (even/odd addresses), so a second hash context can be keyed while the other slot is in use.

## Interface
- No parameters.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset; synchronous, active-high.
- `start`  input  1  one-cycle request; sampled only while `busy`=0.
- `slot`  input  1  target key slot; captured with `start`.
- `key`  input  256  AES-256 key; captured with `start`.
- `busy`  output  1  expansion in progress.
- `done`  output  1  one-cycle pulse coincident with the last write.
- `we`  output  1  key RAM write enable.
- `waddr`  output  5  key RAM write address, `{round[3:0], slot}`.
- `din`  output  128  round key data.

## Operation
- Byte order is little-endian throughout:
  - key byte n sits at `key[8n+7:8n]`;
  - round key word j sits at `[32j+31:32j]`;
  - byte b of a word sits at `[8b+7:8b]`.
- Round keys:
  - RK0 = `key[127:0]`.
  - RK1 = `key[255:128]`.
  - RK2..RK9 follow the AES-256 schedule over words w[i], with i from 8 to 39.
- Schedule, per word: t = w[i-1].
  - If i%8==0: t = SubWord(RotWord(t)) ^ Rcon.
  - If i%8==4: t = SubWord(t).
  - Then w[i] = w[i-8] ^ t.
- RotWord = `{t[7:0], t[31:8]}`. Rcon is XORed into byte 0: 8'h01, 02, 04, 08 for i = 8, 16, 24, 32.
- Hardware per cycle: one RK (4 words) computed combinationally from the previous two RKs held in registers. Needs 4 S-box instances (SubWord on one word), fully combinational.
- FSM states:
  - IDLE → RUN on `start`.
  - RUN counts `round` 0..9.
  - RUN → IDLE after the round-9 write.
- Writes go to addresses `{round, slot}`, which fall in 0..19. No other addresses are ever written.
- `start` while `busy`=1 is ignored entirely: no restart, no recapture.
- `key` and `slot` may change freely after the capture cycle.

## Timing
- Reset values: `busy`=0, `done`=0, `we`=0, `waddr`=0, `din`=0, FSM=IDLE, round=0.
- `start` sampled at edge E0. Writes are registered outputs:
  - RK0 is presented in the cycle after E0 (`we`=1, `waddr`={0,slot}).
  - RK1..RK9 follow in the next 9 consecutive cycles.
  - This gives exactly 10 write cycles with no gaps.
- `busy`=1 during exactly those 10 cycles.
- `done`=1 only in the RK9 write cycle.
- When `we`=0, `din` and `waddr` hold their last values.
- A new `start` is accepted in the RK9 cycle's following cycle at earliest, since `busy` is then 0. Back-to-back jobs therefore have a minimum 1-cycle gap with `we`=0.
- `rst` mid-run:
  - next cycle `we`=0, `busy`=0, `done`=0;
  - no further writes;
  - the partial slot contents are undefined and the producer must rerun.
- `rst` and `start` in the same cycle: `rst` wins and `start` is dropped.
- Downstream must not read a slot until `done` has been seen. The key RAM read path has 2-cycle latency; that is the reader's concern.

## Test plan
- Key bytes 00..1f, slot=0, single start → 10 writes at addresses 0, 2, …, 18:
  - RK0 = 128'h0f0e0d0c0b0a09080706050403020100;
  - RK2 bytes a5 73 c2 9f a1 76 c4 98 a9 7f ce 93 a5 72 c0 9c (`din[31:0]`=32'h9fc273a5);
  - RK3 bytes 16 51 a8 cd 02 44 be da 1a 5d a4 c1 06 40 ba de;
  - RK9 matches the FIPS-197 C.3 round[9] schedule;
  - `done` appears at the addr-18 write only.
- Same key, slot=1 → identical data at addresses 1, 3, …, 19; no even address written.
- `start` pulsed again on cycles 3 and 9 of a run with a different key and slot → ignored; all 10 writes carry the original key/slot; `busy` high exactly 10 cycles.
- `rst` asserted in the 5th write cycle → exactly 4 prior writes; `we`/`busy`/`done`=0 from the next cycle; a fresh start then produces a full correct sequence.
- Random keys, 200 jobs, random slots and inter-job gaps (including the minimum gap) → every written RK matches a reference AES-256 schedule model; write count per job = 10.
- `rst` and `start` in the same cycle → no writes; `busy` stays 0.

Source files
------------

// File: rtl/key_expand.sv
// key_expand: AES-256 round key generator for the CryptoNight key RAM.
// Streams RK0..RK9 into one interleaved slot, one round key per cycle.
module key_expand (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         slot,
    input  logic [255:0] key,
    output logic         busy,
    output logic         done,
    output logic         we,
    output logic [4:0]   waddr,
    output logic [127:0] din
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = 11'd2047 - {x, 3'b000};
        return SBOX[idx -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]),
                sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    logic [0:0]   state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic         slot_q, slot_d;
    logic [127:0] prev_q, prev_d;
    logic [127:0] din_q, din_d;
    logic [4:0]   waddr_q, waddr_d;
    logic         we_q, we_d;
    logic         done_q, done_d;

    logic [3:0]   rnd_n;
    logic [31:0]  rot_w;
    logic [31:0]  sub_in;
    logic [31:0]  t;
    logic [7:0]   rcon;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] next_rk;

    // Next round key from the two most recent ones (prev_q, din_q).
    always_comb begin
        rnd_n  = round_q + 4'd1;
        rot_w  = {din_q[103:96], din_q[127:104]};
        sub_in = rnd_n[0] ? din_q[127:96] : rot_w;
        rcon   = 8'h01 << (rnd_n[3:1] - 3'd1);
        t      = sub_word(sub_in);
        if (!rnd_n[0]) begin
            t[7:0] = t[7:0] ^ rcon;
        end
        n0      = prev_q[31:0] ^ t;
        n1      = prev_q[63:32] ^ n0;
        n2      = prev_q[95:64] ^ n1;
        n3      = prev_q[127:96] ^ n2;
        next_rk = {n3, n2, n1, n0};
    end

    // Sequencer: capture on start, then one registered write per round.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        slot_d  = slot_q;
        prev_d  = prev_q;
        din_d   = din_q;
        waddr_d = waddr_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    round_d = 4'd0;
                    slot_d  = slot;
                    din_d   = key[127:0];
                    prev_d  = key[255:128];
                    waddr_d = {4'd0, slot};
                    we_d    = 1'b1;
                end
            end
            RUN: begin
                if (round_q == 4'd9) begin
                    state_d = IDLE;
                end else begin
                    round_d = rnd_n;
                    din_d   = (round_q == 4'd0) ? prev_q : next_rk;
                    prev_d  = din_q;
                    waddr_d = {rnd_n, slot_q};
                    we_d    = 1'b1;
                    done_d  = (rnd_n == 4'd9);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered write-port outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            round_q <= 4'd0;
            slot_q  <= 1'b0;
            prev_q  <= '0;
            din_q   <= '0;
            waddr_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            slot_q  <= slot_d;
            prev_q  <= prev_d;
            din_q   <= din_d;
            waddr_q <= waddr_d;
            we_q    <= we_d;
            done_q  <= done_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = done_q;
    assign we    = we_q;
    assign waddr = waddr_q;
    assign din   = din_q;
endmodule
